// File: rtl/rriot_arb_pkg.sv
// Shared types and idle-bus constants for the mcs6530 RRIOT bus arbiter.
package rriot_arb_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOST_ADDR = 2'd1,
        HOST_WAIT = 2'd2,
        HOST_ACK  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

    // RS0=0 with CS1=1 selects no region, so an idle bus never touches timer/IO
    localparam logic IDLE_RS0  = 1'b0;
    localparam logic IDLE_CS1  = 1'b1;
    localparam logic IDLE_WE_N = 1'b1;

    typedef struct packed {
        logic              we_n;
        logic [ADDR_W-1:0] a;
        logic              rs0;
        logic              cs1;
        logic [DATA_W-1:0] di;
    } bus_req_t;

    function automatic bus_req_t idle_bus();
        bus_req_t b;
        b.we_n = IDLE_WE_N;
        b.a    = '0;
        b.rs0  = IDLE_RS0;
        b.cs1  = IDLE_CS1;
        b.di   = '0;
        return b;
    endfunction

endpackage

// File: rtl/rriot_starve_ctr.sv
// Saturating counter of consecutive refused host cycles; at_limit is registered.
module rriot_starve_ctr #(
    parameter int unsigned LIMIT = 4,
    parameter int unsigned W     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            at_limit <= (LIMIT == 0);
        end else if (clr) begin
            cnt      <= '0;
            at_limit <= (LIMIT == 0);
        end else if (inc && !at_limit) begin
            cnt      <= cnt + W'(1);
            at_limit <= ((cnt + W'(1)) == LIMIT_V);
        end
    end

endmodule

// File: rtl/rriot_bus_arbiter.sv
// Shares the mcs6530 bus between the 6502 (priority, stalled via RDY) and a host port.
// Build option RRIOT_ARB_ROM_PROTECT_EN blocks host writes to rs0=1/cs1=1 and flags host_err.
module rriot_bus_arbiter
    import rriot_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned READ_LAT     = 1,
    parameter int unsigned CNT_W        = 4
) (
    input  logic                phi2,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic                cpu_we_n,
    input  logic [ADDR_W-1:0]   cpu_a,
    input  logic                cpu_rs0,
    input  logic                cpu_cs1,
    input  logic [DATA_W-1:0]   cpu_di,
    output logic [DATA_W-1:0]   cpu_do,
    output logic                cpu_rdy,
    input  logic                host_req,
    input  logic                host_we_n,
    input  logic [ADDR_W-1:0]   host_a,
    input  logic                host_rs0,
    input  logic                host_cs1,
    input  logic [DATA_W-1:0]   host_di,
    output logic                host_ack,
    output logic [DATA_W-1:0]   host_do,
    output logic                host_err,
    output logic                dev_we_n,
    output logic [ADDR_W-1:0]   dev_a,
    output logic                dev_rs0,
    output logic                dev_cs1,
    output logic [DATA_W-1:0]   dev_di,
    input  logic [DATA_W-1:0]   dev_do,
    input  logic                dev_oe,
    output logic [1:0]          owner
);

    localparam int unsigned      LAT_W     = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [LAT_W-1:0] LAST_WAIT = LAT_W'(READ_LAT - 1);

    state_t           state, state_next;
    owner_t           own;
    bus_req_t         bus, cpu_bus, host_bus, lat;
    logic             lat_err;
    logic             grant, starve_inc, at_limit;
    logic [LAT_W-1:0] wait_cnt;
    logic             wait_last;

    assign cpu_bus   = '{cpu_we_n, cpu_a, cpu_rs0, cpu_cs1, cpu_di};
    assign host_bus  = '{host_we_n, host_a, host_rs0, host_cs1, host_di};
    assign wait_last = (wait_cnt == LAST_WAIT);

    assign dev_we_n = bus.we_n;
    assign dev_a    = bus.a;
    assign dev_rs0  = bus.rs0;
    assign dev_cs1  = bus.cs1;
    assign dev_di   = bus.di;
    assign owner    = own;

    rriot_starve_ctr #(
        .LIMIT (STARVE_LIMIT),
        .W     (CNT_W)
    ) u_starve (
        .clk      (phi2),
        .rst      (rst),
        .inc      (starve_inc),
        .clr      (grant),
        .at_limit (at_limit)
    );

    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, bus mux and CPU handshake
    always_comb begin
        state_next = state;
        bus        = idle_bus();
        own        = OWN_IDLE;
        cpu_rdy    = 1'b1;
        cpu_do     = '0;
        grant      = 1'b0;
        starve_inc = 1'b0;
        case (state)
            IDLE: begin
                grant      = host_req && (!cpu_req || at_limit);
                starve_inc = host_req && !grant;
                if (grant) begin
                    state_next = HOST_ADDR;
                    cpu_rdy    = !cpu_req;
                end else if (cpu_req) begin
                    bus    = cpu_bus;
                    cpu_do = dev_do;
                    own    = OWN_CPU;
                end
            end
            HOST_ADDR: begin
                bus        = lat;
                bus.we_n   = lat.we_n | lat_err;
                own        = OWN_HOST;
                cpu_rdy    = 1'b0;
                state_next = HOST_WAIT;
            end
            HOST_WAIT: begin
                // Address held for the read, but the strobe is never repeated
                bus      = lat;
                bus.we_n = 1'b1;
                own      = OWN_HOST;
                cpu_rdy  = 1'b0;
                if (wait_last) begin
                    state_next = HOST_ACK;
                end
            end
            HOST_ACK: begin
                cpu_rdy    = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Host request latch, wait counter and host response registers
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            lat      <= idle_bus();
            wait_cnt <= '0;
            host_ack <= 1'b0;
            host_do  <= '0;
        end else begin
            if (grant) begin
                lat <= host_bus;
            end
            if (state == HOST_WAIT) begin
                wait_cnt <= wait_cnt + LAT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (state == HOST_WAIT && wait_last) begin
                host_do <= (lat.we_n && dev_oe) ? dev_do : '0;
            end
            host_ack <= (state_next == HOST_ACK);
        end
    end

`ifdef RRIOT_ARB_ROM_PROTECT_EN
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            lat_err  <= 1'b0;
            host_err <= 1'b0;
        end else begin
            if (grant) begin
                lat_err <= !host_we_n && host_rs0 && host_cs1;
            end
            host_err <= (state_next == HOST_ACK) && lat_err;
        end
    end
`else
    assign lat_err  = 1'b0;
    assign host_err = 1'b0;
`endif

endmodule

// File: tb/tb_rriot_bus_arbiter.sv
// Directed bench for rriot_bus_arbiter: host responses checked by a scoreboard monitor on host_ack.
module tb_rriot_bus_arbiter;

`ifdef RRIOT_ARB_ROM_PROTECT_EN
    localparam bit ROM_PROT = 1'b1;
`else
    localparam bit ROM_PROT = 1'b0;
`endif

    logic       phi2;
    logic       rst;
    logic       cpu_req, cpu_we_n, cpu_rs0, cpu_cs1, cpu_rdy;
    logic [9:0] cpu_a;
    logic [7:0] cpu_di, cpu_do;
    logic       host_req, host_we_n, host_rs0, host_cs1, host_ack, host_err;
    logic [9:0] host_a;
    logic [7:0] host_di, host_do;
    logic       dev_we_n, dev_rs0, dev_cs1, dev_oe;
    logic [9:0] dev_a;
    logic [7:0] dev_di, dev_do;
    logic [1:0] owner;

    rriot_bus_arbiter #(
        .STARVE_LIMIT (4),
        .READ_LAT     (1),
        .CNT_W        (4)
    ) dut (
        .phi2      (phi2),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we_n  (cpu_we_n),
        .cpu_a     (cpu_a),
        .cpu_rs0   (cpu_rs0),
        .cpu_cs1   (cpu_cs1),
        .cpu_di    (cpu_di),
        .cpu_do    (cpu_do),
        .cpu_rdy   (cpu_rdy),
        .host_req  (host_req),
        .host_we_n (host_we_n),
        .host_a    (host_a),
        .host_rs0  (host_rs0),
        .host_cs1  (host_cs1),
        .host_di   (host_di),
        .host_ack  (host_ack),
        .host_do   (host_do),
        .host_err  (host_err),
        .dev_we_n  (dev_we_n),
        .dev_a     (dev_a),
        .dev_rs0   (dev_rs0),
        .dev_cs1   (dev_cs1),
        .dev_di    (dev_di),
        .dev_do    (dev_do),
        .dev_oe    (dev_oe),
        .owner     (owner)
    );

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    // Device stand-in: RAM selected by rs0=0,cs1=0, registered read data
    logic [7:0] mem [1024];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        dev_do = 8'h00;
        dev_oe = 1'b0;
    end
    always @(posedge phi2) begin
        if (!dev_we_n && !dev_rs0 && !dev_cs1) mem[dev_a] <= dev_di;
        dev_do <= mem[dev_a];
        dev_oe <= dev_we_n && !dev_rs0 && !dev_cs1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] d;
        logic       e;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge phi2) begin
        if (host_ack) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_host_ack", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("host_do", 32'(host_do), 32'(mon_e.d));
                chk("host_err", 32'(host_err), 32'(mon_e.e));
            end
        end
    end

    // Runs one host transaction; g = cycles of refusal before the grant cycle
    task automatic host_txn(input logic we_n, input logic [9:0] a, input logic rs0,
                            input logic cs1, input logic [7:0] di, input logic [7:0] exp_do,
                            input logic exp_err, input int g, input bit release_req);
        int   rdy_low = 0;
        int   wr      = 0;
        int   exp_wr;
        exp_t e;
        exp_wr    = (!we_n && !(ROM_PROT && rs0 && cs1)) ? 1 : 0;
        host_req  = 1'b1;
        host_we_n = we_n;
        host_a    = a;
        host_rs0  = rs0;
        host_cs1  = cs1;
        host_di   = di;
        e.d = exp_do;
        e.e = exp_err;
        exp_q.push_back(e);
        for (int k = 0; k <= g + 3; k++) begin
            @(negedge phi2);
            if (!cpu_rdy) rdy_low++;
            if (!dev_we_n) wr++;
            chk("host_ack_timing", 32'(host_ack), 32'(k == g + 3));
            if (k < g) begin
                chk("refused_cpu_rdy", 32'(cpu_rdy), 32'd1);
                chk("refused_owner", 32'(owner), 32'd1);
            end else if (k == g) begin
                chk("grant_cpu_rdy", 32'(cpu_rdy), 32'(!cpu_req));
                chk("grant_owner", 32'(owner), 32'd0);
            end else if (k < g + 3) begin
                chk("host_owner", 32'(owner), 32'd2);
            end
        end
        chk("cpu_rdy_low_cycles", 32'(rdy_low), cpu_req ? 32'd4 : 32'd3);
        chk("write_pulses", 32'(wr), 32'(exp_wr));
        if (release_req) host_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we_n = 1'b1; cpu_a = '0; cpu_rs0 = 1'b0; cpu_cs1 = 1'b1; cpu_di = '0;
        host_req = 1'b0; host_we_n = 1'b1; host_a = '0; host_rs0 = 1'b0; host_cs1 = 1'b1; host_di = '0;

        @(negedge phi2);
        chk("rst_cpu_rdy", 32'(cpu_rdy), 32'd1);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_host_ack", 32'(host_ack), 32'd0);
        chk("rst_host_do", 32'(host_do), 32'd0);
        chk("rst_host_err", 32'(host_err), 32'd0);
        chk("rst_dev_we_n", 32'(dev_we_n), 32'd1);
        chk("rst_dev_a", 32'(dev_a), 32'd0);
        chk("rst_dev_rs0", 32'(dev_rs0), 32'd0);
        chk("rst_dev_cs1", 32'(dev_cs1), 32'd1);
        rst = 1'b0;

        // CPU-only RAM write passes straight through
        @(posedge phi2); #1;
        cpu_req = 1'b1; cpu_we_n = 1'b0; cpu_a = 10'h0C5; cpu_rs0 = 1'b0; cpu_cs1 = 1'b0; cpu_di = 8'h5A;
        @(negedge phi2);
        chk("cpu_dev_we_n", 32'(dev_we_n), 32'd0);
        chk("cpu_dev_a", 32'(dev_a), 32'h0C5);
        chk("cpu_dev_di", 32'(dev_di), 32'h5A);
        chk("cpu_rdy", 32'(cpu_rdy), 32'd1);
        chk("cpu_owner", 32'(owner), 32'd1);
        @(posedge phi2); #1;
        cpu_req = 1'b0; cpu_we_n = 1'b1;

        // Host read with the CPU idle
        host_txn(1'b1, 10'h0C5, 1'b0, 1'b0, 8'h00, 8'h5A, 1'b0, 0, 1'b1);

        // Starvation: CPU reads continuously, host preempts after 4 refusals, twice
        @(posedge phi2); #1;
        cpu_req = 1'b1; cpu_we_n = 1'b1; cpu_a = 10'h0C5; cpu_rs0 = 1'b0; cpu_cs1 = 1'b0;
        host_txn(1'b1, 10'h0C5, 1'b0, 1'b0, 8'h00, 8'h5A, 1'b0, 4, 1'b1);
        @(negedge phi2);
        chk("resume_cpu_rdy", 32'(cpu_rdy), 32'd1);
        chk("resume_owner", 32'(owner), 32'd1);
        @(posedge phi2); #1;
        host_txn(1'b1, 10'h0C5, 1'b0, 1'b0, 8'h00, 8'h5A, 1'b0, 4, 1'b1);
        @(posedge phi2); #1;
        cpu_req = 1'b0;

        // Host write with req held, then back-to-back read of the same byte
        host_txn(1'b0, 10'h0C6, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b0, 0, 1'b0);
        host_txn(1'b1, 10'h0C6, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0, 0, 1'b1);

        // Host write into the ROM region
        @(posedge phi2); #1;
        host_txn(1'b0, 10'h010, 1'b1, 1'b1, 8'h33, 8'h00, ROM_PROT, 0, 1'b1);

        // Reset during HOST_WAIT aborts without an ack
        @(posedge phi2); #1;
        host_req = 1'b1; host_we_n = 1'b1; host_a = 10'h0C5; host_rs0 = 1'b0; host_cs1 = 1'b0;
        repeat (3) @(negedge phi2);
        chk("wait_owner", 32'(owner), 32'd2);
        rst = 1'b1;
        host_req = 1'b0;
        #1;
        chk("abort_dev_we_n", 32'(dev_we_n), 32'd1);
        chk("abort_dev_a", 32'(dev_a), 32'd0);
        chk("abort_dev_rs0", 32'(dev_rs0), 32'd0);
        chk("abort_dev_cs1", 32'(dev_cs1), 32'd1);
        chk("abort_owner", 32'(owner), 32'd0);
        chk("abort_cpu_rdy", 32'(cpu_rdy), 32'd1);
        chk("abort_host_ack", 32'(host_ack), 32'd0);
        repeat (2) @(negedge phi2);
        rst = 1'b0;
        repeat (4) @(negedge phi2);
        chk("pending_responses", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
